// File: rtl/vctrl_pkg.sv
// Shared constants and helpers for the vector control register file.
package vctrl_pkg;

  localparam int VL_ADDR = 0;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_LOG2DEPTH  = 5;
  localparam int DEF_NUMRDPORTS = 2;
  localparam int DEF_NUMMASKS   = 3;
  localparam int DEF_MASKW      = 8;
  localparam int DEF_MVL        = 64;

  function automatic int mask_addr(
    input int i,
    input int log2depth
  );
    return (1 << log2depth) - 1 - i;
  endfunction

  function automatic logic [63:0] clamp_vl(
    input logic [63:0] data,
    input logic [63:0] mvl
  );
    return (data > mvl) ? mvl : data;
  endfunction

endpackage

// File: rtl/vctrl_rdport.sv
// One registered read port of the control register file.
// Build with VCTRL_WR_BYPASS_EN for write-first same-address reads.
module vctrl_rdport
  import vctrl_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LOG2DEPTH = DEF_LOG2DEPTH,
  parameter int DEPTH     = 2 ** LOG2DEPTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DEPTH-1:0][WIDTH-1:0]     mem,
  input  logic                            rd_en,
  input  logic [LOG2DEPTH-1:0]            rd_reg,
  input  logic                            wr_we,
  input  logic [LOG2DEPTH-1:0]            wr_reg,
  input  logic [WIDTH-1:0]                wr_val,
  output logic [WIDTH-1:0]                rd_data
);

  logic [WIDTH-1:0] sel;

`ifdef VCTRL_WR_BYPASS_EN
  always_comb begin
    sel = mem[rd_reg];
    if (wr_we && (wr_reg == rd_reg))
      sel = wr_val;
  end
`else
  logic unused_wr;
  assign unused_wr = ^{wr_we, wr_reg, wr_val};

  always_comb begin
    sel = mem[rd_reg];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= sel;
  end

endmodule

// File: rtl/vregfile_control_mp.sv
// Multi-read-port vector control register file with vl/mask promotion.
// Optional macro VCTRL_WR_BYPASS_EN selects write-first read ports.
module vregfile_control_mp
  import vctrl_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LOG2DEPTH  = DEF_LOG2DEPTH,
  parameter int NUMRDPORTS = DEF_NUMRDPORTS,
  parameter int NUMMASKS   = DEF_NUMMASKS,
  parameter int MASKW      = DEF_MASKW,
  parameter int MVL        = DEF_MVL
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUMRDPORTS-1:0]             rd_en,
  input  logic [NUMRDPORTS*LOG2DEPTH-1:0]   rd_reg,
  output logic [NUMRDPORTS*WIDTH-1:0]       rd_data,
  input  logic [LOG2DEPTH-1:0]              wr_reg,
  input  logic [WIDTH-1:0]                  wr_data,
  input  logic                              wr_we,
  input  logic                              clr_status,
  output logic [WIDTH-1:0]                  vl,
  output logic [NUMMASKS*MASKW-1:0]         masks,
  output logic                              vl_clamped
);

  localparam int DEPTH = 2 ** LOG2DEPTH;

  if (NUMMASKS >= DEPTH) begin : g_err_masks
    $error("NUMMASKS must be less than DEPTH");
  end
  if (MASKW > WIDTH) begin : g_err_maskw
    $error("MASKW must not exceed WIDTH");
  end
  if (WIDTH > 64) begin : g_err_width
    $error("WIDTH above 64 not supported by clamp_vl");
  end
  if (WIDTH < 64 && 64'(MVL) >= (64'd1 << WIDTH)) begin : g_err_mvl
    $error("MVL must fit in WIDTH bits");
  end

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        is_vl;
  logic                        over;
  logic [WIDTH-1:0]            wr_val;

  assign is_vl = (wr_reg == LOG2DEPTH'(VL_ADDR));
  assign over  = is_vl && (64'(wr_data) > 64'(MVL));

  // VL is stored clamped so reads and vl agree
  assign wr_val = is_vl
                ? WIDTH'(clamp_vl(64'(wr_data), 64'(MVL)))
                : wr_data;

  always_ff @(posedge clk) begin
    if (!reset && wr_we)
      mem[wr_reg] <= wr_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vl         <= '0;
      masks      <= '1;
      vl_clamped <= 1'b0;
    end else begin
      if (wr_we && is_vl)
        vl <= wr_val;
      for (int i = 0; i < NUMMASKS; i++) begin
        if (wr_we &&
            wr_reg == LOG2DEPTH'(mask_addr(i, LOG2DEPTH)))
          masks[i*MASKW +: MASKW] <= wr_data[MASKW-1:0];
      end
      if (wr_we && over)
        vl_clamped <= 1'b1;
      else if (clr_status)
        vl_clamped <= 1'b0;
    end
  end

  for (genvar p = 0; p < NUMRDPORTS; p++) begin : g_rd
    vctrl_rdport #(
      .WIDTH     (WIDTH),
      .LOG2DEPTH (LOG2DEPTH)
    ) u_rdport (
      .clk     (clk),
      .reset   (reset),
      .mem     (mem),
      .rd_en   (rd_en[p]),
      .rd_reg  (rd_reg[p*LOG2DEPTH +: LOG2DEPTH]),
      .wr_we   (wr_we),
      .wr_reg  (wr_reg),
      .wr_val  (wr_val),
      .rd_data (rd_data[p*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_vregfile_control_mp.sv
// Self-checking bench for vregfile_control_mp (default parameters).
module tb_vregfile_control_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rd_en;
  logic [9:0]  rd_reg;
  logic [63:0] rd_data;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic        wr_we;
  logic        clr_status;
  logic [31:0] vl;
  logic [23:0] masks;
  logic        vl_clamped;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_mem [32];
  logic [31:0] m_rd  [2];
  logic [31:0] m_vl;
  logic [23:0] m_masks;
  logic        m_flag;

  always #5 clk = ~clk;

  vregfile_control_mp dut (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rd_en),
    .rd_reg     (rd_reg),
    .rd_data    (rd_data),
    .wr_reg     (wr_reg),
    .wr_data    (wr_data),
    .wr_we      (wr_we),
    .clr_status (clr_status),
    .vl         (vl),
    .masks      (masks),
    .vl_clamped (vl_clamped)
  );

  // Apply one cycle of inputs, advance the reference model, wait the edge.
  task automatic cycle(
    input logic       rst,
    input logic [1:0] en,
    input logic [4:0] r0,
    input logic [4:0] r1,
    input logic       we,
    input logic [4:0] wa,
    input logic [31:0] wd,
    input logic       clr
  );
    logic [31:0] nv;
    logic [4:0]  ra;
    reset      = rst;
    rd_en      = en;
    rd_reg     = {r1, r0};
    wr_we      = we;
    wr_reg     = wa;
    wr_data    = wd;
    clr_status = clr;
    nv = (wa == 5'd0 && wd > 32'd64) ? 32'd64 : wd;
    if (rst) begin
      m_rd[0] = '0;
      m_rd[1] = '0;
      m_vl    = '0;
      m_masks = '1;
      m_flag  = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (en[p]) begin
          ra = (p == 1) ? r1 : r0;
          m_rd[p] = m_mem[ra];
`ifdef VCTRL_WR_BYPASS_EN
          if (we && wa == ra) m_rd[p] = nv;
`endif
        end
      end
      if (clr) m_flag = 1'b0;
      if (we) begin
        m_mem[wa] = nv;
        if (wa == 5'd0) begin
          m_vl = nv;
          if (wd > 32'd64) m_flag = 1'b1;
        end
        if (wa >= 5'd29)
          m_masks[(31 - int'(wa))*8 +: 8] = wd[7:0];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic test_reset();
    cycle(1'b1, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle(1'b1, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    idle();
    total++;
    if (vl !== 32'd0) begin
      bad++;
      $display("FAIL reset_vl got=%h want=0", vl);
    end
    total++;
    if (masks !== 24'hFFFFFF) begin
      bad++;
      $display("FAIL reset_masks got=%h want=ffffff", masks);
    end
    total++;
    if (vl_clamped !== 1'b0) begin
      bad++;
      $display("FAIL reset_flag got=%b want=0", vl_clamped);
    end
    total++;
    if (rd_data !== 64'd0) begin
      bad++;
      $display("FAIL reset_rd got=%h want=0", rd_data);
    end
  endtask

  task automatic test_vl_write();
    cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 32'd40, 1'b0);
    total++;
    if (vl !== 32'd40) begin
      bad++;
      $display("FAIL vl_write got=%0d want=40", vl);
    end
    cycle(1'b0, 2'b01, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    total++;
    if (rd_data[31:0] !== 32'd40) begin
      bad++;
      $display("FAIL vl_read got=%0d want=40", rd_data[31:0]);
    end
  endtask

  task automatic test_clamp();
    cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 32'd64, 1'b0);
    total++;
    if (vl !== 32'd64 || vl_clamped !== 1'b0) begin
      bad++;
      $display("FAIL clamp_eq got=%0d/%b want=64/0", vl, vl_clamped);
    end
    cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 32'd100, 1'b0);
    total++;
    if (vl !== 32'd64 || vl_clamped !== 1'b1) begin
      bad++;
      $display("FAIL clamp_100 got=%0d/%b want=64/1", vl, vl_clamped);
    end
    cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 32'd200, 1'b1);
    total++;
    if (vl_clamped !== 1'b1) begin
      bad++;
      $display("FAIL clamp_setwins got=%b want=1", vl_clamped);
    end
    cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    total++;
    if (vl_clamped !== 1'b0) begin
      bad++;
      $display("FAIL clamp_clear got=%b want=0", vl_clamped);
    end
  endtask

  task automatic test_masks();
    for (int a = 31; a >= 29; a--)
      cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'(a), 32'h1234_56AB, 1'b0);
    total++;
    if (masks !== 24'hABABAB) begin
      bad++;
      $display("FAIL masks got=%h want=ababab", masks);
    end
    cycle(1'b0, 2'b10, 5'd0, 5'd30, 1'b0, 5'd0, 32'd0, 1'b0);
    total++;
    if (rd_data[63:32] !== 32'h1234_56AB) begin
      bad++;
      $display("FAIL mask_read got=%h want=123456ab", rd_data[63:32]);
    end
  endtask

  task automatic test_rdw();
    logic [31:0] want;
`ifdef VCTRL_WR_BYPASS_EN
    want = 32'd9;
`else
    want = 32'd7;
`endif
    cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 32'd7, 1'b0);
    cycle(1'b0, 2'b11, 5'd5, 5'd5, 1'b1, 5'd5, 32'd9, 1'b0);
    total++;
    if (rd_data !== {want, want}) begin
      bad++;
      $display("FAIL rdw got=%h want=%h", rd_data, {want, want});
    end
    cycle(1'b0, 2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0);
    total++;
    if (rd_data !== {32'd9, 32'd9}) begin
      bad++;
      $display("FAIL rdw_after got=%h want=9/9", rd_data);
    end
  endtask

  task automatic test_reset_block();
    cycle(1'b1, 2'b11, 5'd0, 5'd0, 1'b1, 5'd0, 32'd10, 1'b0);
    total++;
    if (vl !== 32'd0 || rd_data !== 64'd0) begin
      bad++;
      $display("FAIL rst_block got=%0d/%h want=0/0", vl, rd_data);
    end
    cycle(1'b0, 2'b01, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    total++;
    if (rd_data[31:0] !== 32'd64) begin
      bad++;
      $display("FAIL rst_keep got=%0d want=64", rd_data[31:0]);
    end
  endtask

  task automatic test_random();
    logic        rst, we, clr;
    logic [1:0]  en;
    logic [4:0]  r0, r1, wa;
    logic [31:0] wd;
    for (int a = 0; a < 32; a++)
      cycle(1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'(a), $urandom, 1'b0);
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      en  = 2'($urandom);
      wa  = 5'($urandom);
      r0  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      r1  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      we  = 1'($urandom);
      wd  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 130))
                                         : $urandom;
      clr = ($urandom_range(0, 7) == 0);
      cycle(rst, en, r0, r1, we, wa, wd, clr);
      total++;
      if (rd_data !== {m_rd[1], m_rd[0]} || vl !== m_vl ||
          masks !== m_masks || vl_clamped !== m_flag) begin
        bad++;
        $display("FAIL rand[%0d] got=%h/%h/%h/%b want=%h/%h/%h/%b",
                 n, rd_data, vl, masks, vl_clamped,
                 {m_rd[1], m_rd[0]}, m_vl, m_masks, m_flag);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vl_write();
    test_clamp();
    test_masks();
    test_rdw();
    test_reset_block();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
